uart_receiver: RTL

Serial-to-parallel UART receive engine, the counterpart of the transmit-side send sequencing in the UART datapath. It samples the asynchronous serial line, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed clocks-per-bit divisor, and presents each byte with a one-cycle valid strobe. It also flags framing errors and reports an active-low busy status for downstream consumers.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_receiver.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
// Holds the frame geometry, the default baud divisor and the receiver state encoding.
package uart_pkg;

   localparam int DATA_BITS       = 8;
   localparam int DEFAULT_DIVISOR = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rxState_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets what both flops hold during reset, e.g. 1 for an idle-high line.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clkIN,
   input  logic resetIN,
   input  logic asyncIN,
   output logic syncOUT
);

   logic meta;

   // First stage may go metastable; the second stage gives it a full cycle to settle
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) begin
         meta    <= RESET_VAL;
         syncOUT <= RESET_VAL;
      end else begin
         meta    <= asyncIN;
         syncOUT <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: recovers bytes from rxIN at DIVISOR clocks per bit.
// Emits a one-cycle valid or framing-error strobe per frame plus an active-low busy flag.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DIVISOR = DEFAULT_DIVISOR
) (
   input  logic                 clkIN,
   input  logic                 resetIN,
   input  logic                 rxIN,
   output logic [DATA_BITS-1:0] dataOUT,
   output logic                 validOUT,
   output logic                 frameErrOUT,
   output logic                 nBusyOUT
);

   localparam int HALF = DIVISOR / 2;
   localparam int CW   = $clog2(DIVISOR);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

   rxState_t             state;
   logic                 rxS;
   logic                 prevRxS;
   logic                 startEdge;
   logic [CW-1:0]        cnt;
   logic [2:0]           bitIdx;
   logic [DATA_BITS-1:0] shiftReg;

   uart_sync2 #(
      .RESET_VAL(1'b1)
   ) rxSync (
      .clkIN  (clkIN),
      .resetIN(resetIN),
      .asyncIN(rxIN),
      .syncOUT(rxS)
   );

   // A held-low line never re-arms this, so a break reports only once
   assign startEdge = prevRxS & ~rxS;

   // Frame sequencer: every sample lands at cnt==0, half a bit after the start edge and then once per bit
   always_ff @(posedge clkIN or posedge resetIN) begin
      if (resetIN) begin
         state       <= IDLE;
         prevRxS     <= 1'b1;
         cnt         <= '0;
         bitIdx      <= '0;
         shiftReg    <= '0;
         dataOUT     <= '0;
         validOUT    <= 1'b0;
         frameErrOUT <= 1'b0;
         nBusyOUT    <= 1'b1;
      end else begin
         prevRxS     <= rxS;
         validOUT    <= 1'b0;
         frameErrOUT <= 1'b0;
         case (state)
            IDLE: begin
               if (startEdge) begin
                  cnt      <= HALF_LOAD;
                  state    <= START;
                  nBusyOUT <= 1'b0;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (rxS) begin
                     state    <= IDLE;
                     nBusyOUT <= 1'b1;
                  end else begin
                     cnt    <= FULL_LOAD;
                     bitIdx <= '0;
                     state  <= DATA;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                  cnt      <= FULL_LOAD;
                  if (bitIdx == LAST_BIT) begin
                     state <= STOP;
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid-stop lets a start bit that follows with no idle gap be caught
               if (cnt == '0) begin
                  if (rxS) begin
                     dataOUT  <= shiftReg;
                     validOUT <= 1'b1;
                  end else begin
                     frameErrOUT <= 1'b1;
                  end
                  state    <= IDLE;
                  nBusyOUT <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               nBusyOUT <= 1'b1;
            end
         endcase
      end
   end

endmodule
